result_uart_tx: RTL and testbench

//  Drains the processor's result stream (64-bit data word + 1-cycle enable strobe) off-chip over UART 8N1.

---
 rtl/result_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_result_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// Drains a 64-bit result stream over UART 8N1, most-significant byte first.
// Words are buffered in a small FIFO; words arriving while it is full are dropped and flagged.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_W       = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             data,
    input  logic                          enable,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   words_sent
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int NBYTES = DATA_W / 8;
    localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]      count_r, count_s;
    logic                pop_s, push_s, full_s, drop_s, bit_tc_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [2:0]          bit_idx_r, bit_idx_s;
    logic [BI_W-1:0]     byte_idx_r, byte_idx_s;
    logic [DATA_W-1:0]   shift_r, shift_s;
    logic [7:0]          byte_r, byte_s;
    logic                tx_r, tx_s, busy_r, busy_s, ovf_r;
    logic [15:0]         sent_r, sent_s;

    // FIFO push/pop decisions; a full FIFO still accepts a word when the FSM pops in the same cycle
    always_comb begin
        pop_s    = (state_r == ST_IDLE) && (count_r != {(PTR_W+1){1'b0}});
        full_s   = (count_r == (PTR_W+1)'(FIFO_DEPTH));
        push_s   = enable && (!full_s || pop_s);
        drop_s   = enable && full_s && !pop_s;
        bit_tc_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_s = count_r - (PTR_W+1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Frame sequencer; tx is produced from the current state, so the line lags the state by one cycle
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_idx_s  = bit_idx_r;
        byte_idx_s = byte_idx_r;
        shift_s    = shift_r;
        byte_s     = byte_r;
        sent_s     = sent_r;
        tx_s       = 1'b1;
        case (state_r)
            ST_IDLE: begin
                tx_s  = 1'b1;
                cnt_s = {CNT_W{1'b0}};
                if (pop_s) begin
                    shift_s    = mem_r[rd_ptr_r];
                    byte_idx_s = {BI_W{1'b0}};
                    state_s    = ST_START;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                tx_s = 1'b0;
                if (bit_tc_s) begin
                    cnt_s     = {CNT_W{1'b0}};
                    byte_s    = shift_r[DATA_W-1 -: 8];
                    shift_s   = shift_r << 8;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    cnt_s     = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                tx_s = byte_r[bit_idx_r];
                if (bit_tc_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        state_s   = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (bit_tc_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (byte_idx_r < BI_W'(NBYTES - 1)) begin
                        byte_idx_s = byte_idx_r + BI_W'(1);
                        state_s    = ST_START;
                    end else begin
                        sent_s     = sent_r + 16'd1;
                        state_s    = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                tx_s    = 1'b1;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (count_s != {(PTR_W+1){1'b0}}) || (state_s != ST_IDLE);
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            byte_idx_r <= {BI_W{1'b0}};
            shift_r    <= {DATA_W{1'b0}};
            byte_r     <= 8'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
            sent_r     <= 16'd0;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r   <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            count_r    <= count_s;
            cnt_r      <= cnt_s;
            bit_idx_r  <= bit_idx_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            byte_r     <= byte_s;
            tx_r       <= tx_s;
            busy_r     <= busy_s;
            ovf_r      <= ovf_r | drop_s;
            sent_r     <= sent_s;
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign overflow   = ovf_r;
    assign fifo_count = count_r;
    assign words_sent = sent_r;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: a timing-level reference model checked every cycle,
// a UART receiver decoding the line, a vector table and hand-written corner sequences.
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FT    = 8 * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] data = 64'd0;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_count;
    logic [15:0] words_sent;

    result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_W(64)) dut (
        .clk(clk), .rst(rst), .data(data), .enable(enable), .tx(tx), .busy(busy),
        .overflow(overflow), .fifo_count(fifo_count), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // reference model: queue of buffered words plus the pop time of the word on the line
    logic [63:0] mq[$];
    logic [63:0] popped_q[$];
    logic [63:0] cur_w = 64'd0;
    int          cur_p = -1000;
    bit          active = 1'b0;
    int          idle_from = 0;
    int          sent_m = 0;
    bit          ovf_m = 1'b0;
    int          t = 0;

    // UART receiver state
    logic [63:0] rx_words[$];
    int          start_t[$];
    int          frame_err = 0;

    typedef struct {
        logic [63:0] d;
        int          n;
        int          exp_sent;
        bit          exp_ovf;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // line level of a frame k cycles after it started: start, 8 data bits LSB first, stop, per byte MSB first
    function automatic logic frame_bit(input logic [63:0] w, input int k);
        int idx, pos;
        logic [7:0] b;
        idx = k / CPB;
        pos = idx % 10;
        b   = w[63 - 8 * (idx / 10) -: 8];
        if (pos == 0) return 1'b0;
        else if (pos == 9) return 1'b1;
        else return b[pos - 1];
    endfunction

    task automatic step(input bit en, input logic [63:0] d, input bit r);
        bit   pop;
        int   n0;
        logic exp_tx;
        enable = en;
        data   = d;
        rst    = r;
        @(posedge clk);
        t++;
        if (r) begin
            mq.delete();
            active    = 1'b0;
            sent_m    = 0;
            ovf_m     = 1'b0;
            idle_from = t + 1;
        end else begin
            if (active && t == cur_p + FT) begin
                sent_m = (sent_m + 1) % 65536;
                active = 1'b0;
            end
            n0  = mq.size();
            pop = (n0 > 0) && (t >= idle_from);
            if (pop) begin
                cur_w = mq.pop_front();
                popped_q.push_back(cur_w);
                cur_p = t;
                active = 1'b1;
                idle_from = t + FT + 1;
            end
            if (en) begin
                if (n0 < DEPTH || pop) mq.push_back(d);
                else ovf_m = 1'b1;
            end
        end
        #1;
        exp_tx = (active && t > cur_p) ? frame_bit(cur_w, t - cur_p - 1) : 1'b1;
        check("cycle{tx,busy,ovf,count,sent}",
              64'({tx, busy, overflow, fifo_count, words_sent}),
              64'({exp_tx, (mq.size() > 0) || active, ovf_m, 3'(mq.size()), 16'(sent_m)}));
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b0, 64'd0, 1'b1);
        popped_q.delete();
        rx_words.delete();
        start_t.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && (mq.size() > 0 || active); i++) step(1'b0, 64'd0, 1'b0);
        repeat (8) step(1'b0, 64'd0, 1'b0);
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    // UART receiver sampling at the falling edge, restarted by reset
    initial begin
        bit         on;
        int         k, nb;
        logic [7:0] b;
        logic [63:0] acc;
        on = 1'b0; k = 0; nb = 0; b = 8'd0; acc = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                on = 1'b0;
                nb = 0;
            end else if (!on) begin
                if (tx === 1'b0) begin
                    on = 1'b1;
                    k  = 0;
                    start_t.push_back(t);
                end
            end else begin
                k++;
                if (k % CPB == 0) begin
                    if (k <= 8 * CPB) begin
                        b[k / CPB - 1] = tx;
                    end else begin
                        if (tx !== 1'b1) frame_err++;
                        on  = 1'b0;
                        acc = {acc[55:0], b};
                        nb++;
                        if (nb == 8) begin
                            rx_words.push_back(acc);
                            nb = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int st, target, ns;
        tbl[0] = '{64'h0123_4567_89AB_CDEF, 1, 1, 1'b0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1'b0};
        tbl[2] = '{64'h0000_0000_0000_0000, 1, 1, 1'b0};
        tbl[3] = '{64'hA5A5_5A5A_0F0F_F0F0, 3, 3, 1'b0};
        tbl[4] = '{64'hDEAD_BEEF_CAFE_F00D, 6, 5, 1'b1};
        tbl[5] = '{64'h8000_0000_0000_0001, 5, 5, 1'b0};

        do_reset(3);
        check("reset", 64'({tx, busy, overflow, fifo_count, words_sent}),
              64'({1'b1, 1'b0, 1'b0, 3'd0, 16'd0}));

        foreach (tbl[v]) begin
            do_reset(2);
            st = t + 1;
            for (int i = 0; i < tbl[v].n; i++) step(1'b1, tbl[v].d + 64'(i), 1'b0);
            drain();
            check("latency", 64'(start_t.size() > 0 ? start_t[0] - st : -1), 64'd2);
            check("words_sent", 64'(words_sent), 64'(tbl[v].exp_sent));
            check("overflow", 64'(overflow), 64'(tbl[v].exp_ovf));
            check("nwords", 64'(rx_words.size()), 64'(tbl[v].exp_sent));
            for (int i = 0; i < tbl[v].exp_sent; i++)
                check("word", i < rx_words.size() ? rx_words[i] : 64'hx, tbl[v].d + 64'(i));
        end

        // back-to-back: one extra idle cycle between words
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1'b1, 64'h1111_2222_3333_4444 * 64'(i + 1), 1'b0);
        drain();
        check("gap_byte", 64'(start_t.size() >= 17 ? start_t[16] - start_t[15] : -1), 64'd41);
        check("gap_word", 64'(start_t.size() >= 17 ? start_t[16] - start_t[8] : -1), 64'd321);
        check("b2b_sent", 64'(words_sent), 64'd3);

        // full FIFO with a strobe on the pop cycle
        do_reset(2);
        for (int i = 0; i < 5; i++) step(1'b1, 64'hC0DE_0000_0000_0000 + 64'(i), 1'b0);
        target = idle_from;
        for (int i = 0; i < 1000 && t + 1 < target; i++) step(1'b0, 64'd0, 1'b0);
        step(1'b1, 64'hC0DE_0000_0000_00FF, 1'b0);
        check("full_pushpop_count", 64'(fifo_count), 64'd4);
        check("full_pushpop_ovf", 64'(overflow), 64'd0);
        drain();
        check("full_pushpop_sent", 64'(words_sent), 64'd6);
        check("full_pushpop_last", rx_words.size() == 6 ? rx_words[5] : 64'hx, 64'hC0DE_0000_0000_00FF);

        // reset during byte 3 data bits
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1'b1, 64'h5555_AAAA_5555_AAAA, 1'b0);
        target = cur_p + 1 + CPB * 33;
        for (int i = 0; i < 1000 && t < target; i++) step(1'b0, 64'd0, 1'b0);
        step(1'b0, 64'd0, 1'b1);
        check("midreset_tx", 64'(tx), 64'd1);
        check("midreset_count", 64'(fifo_count), 64'd0);
        ns = start_t.size();
        repeat (400) step(1'b0, 64'd0, 1'b0);
        check("midreset_nostart", 64'(start_t.size()), 64'(ns));
        check("midreset_sent", 64'(words_sent), 64'd0);

        // randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 199) < 3, {$urandom, $urandom}, 1'b0);
        drain();
        check("rand_nwords", 64'(rx_words.size()), 64'(popped_q.size()));
        foreach (popped_q[i])
            check("rand_word", i < rx_words.size() ? rx_words[i] : 64'hx, popped_q[i]);
        check("framing", 64'(frame_err), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
